dct_odd_collector: RTL and testbench

Collects the serial floating-point results of the odd-coefficient CORDIC/adder-tree datapath into complete odd-coefficient frames. It tracks each issued sequencer/angle word through the datapath's fixed pipeline latency and captures the tree output into a ping-pong frame buffer. It presents finished frames of DCT_POINT/2 words to the output reorder stage over a valid/ready handshake. It sits directly downstream of the datapath, and its issue port is driven by the same controller that drives the datapath's sequencer and angle inputs.

---
 rtl/dct_odd_collector.sv | 185 ++++++++++++++++++
 tb/tb_dct_odd_collector.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_odd_collector.sv
// dct_odd_collector
// Tracks issued sequencer/angle words through the datapath latency with a tag pipe,
// captures the datapath results into a ping-pong frame buffer and hands complete
// odd-coefficient frames downstream over a valid/ready handshake.
// Optional: define DCT_COLLECT_ERRCHK_EN for per-bank written masks and a sticky err.
module dct_odd_collector #(
    parameter int unsigned M         = 23,
    parameter int unsigned E         = 8,
    parameter int unsigned DCT_POINT = 16,
    parameter int unsigned LAT       = 12,
    localparam int unsigned W        = M + E + 1,
    localparam int unsigned F        = DCT_POINT / 2,
    localparam int unsigned X        = $clog2(F)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           issue_valid,
    input  logic [X-1:0]   issue_idx,
    output logic           issue_ready,
    input  logic [W-1:0]   dp_out,
    output logic           frame_valid,
    input  logic           frame_ready,
    output logic [W*F-1:0] frame_data
`ifdef DCT_COLLECT_ERRCHK_EN
    ,
    output logic           err
`endif
);

    localparam int unsigned OW = $clog2(2 * F + 1);
    localparam int unsigned CW = $clog2(F + 1);

    logic          accept;
    logic          capture;
    logic          bank_done;
    logic          release_frame;
    logic [X-1:0]  cap_idx;

    logic [LAT-1:0] tag_v_q, tag_v_d;
    logic [X-1:0]   tag_idx_q [LAT];
    logic [X-1:0]   tag_idx_d [LAT];

    logic [CW-1:0] fill_q [2];
    logic [CW-1:0] fill_d [2];
    logic [1:0]    full_q, full_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [OW-1:0] occ_q, occ_d;

    logic [W-1:0]  mem_q [2][F];
    logic [W-1:0]  mem_d [2][F];

    // occ bounds in-flight tags plus held words, so a full bank is never rewritten
    assign issue_ready   = occ_q < OW'(2 * F);
    assign accept        = issue_valid && issue_ready && !clr;
    assign capture       = tag_v_q[LAT-1] && !clr;
    assign cap_idx       = tag_idx_q[LAT-1];
    assign bank_done     = capture && (fill_q[wr_q] == CW'(F - 1));
    assign frame_valid   = full_q[rd_q];
    assign release_frame = frame_valid && frame_ready;

    // Tag pipe: one entry per cycle, valid only for accepted issues
    always_comb begin
        tag_v_d      = '0;
        tag_idx_d[0] = issue_idx;
        tag_v_d[0]   = accept;
        for (int i = 1; i < LAT; i++) begin
            tag_v_d[i]   = tag_v_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
    end

    // Bank bookkeeping: fill counters, full flags and ping-pong pointers
    always_comb begin
        fill_d = fill_q;
        full_d = full_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (capture) begin
            if (bank_done) begin
                fill_d[wr_q] = '0;
                full_d[wr_q] = 1'b1;
                wr_d         = ~wr_q;
            end else begin
                fill_d[wr_q] = fill_q[wr_q] + CW'(1);
            end
        end
        if (release_frame) begin
            full_d[rd_q] = 1'b0;
            rd_d         = ~rd_q;
        end
    end

    // Occupancy: +1 per accepted issue, -F per released frame; captures are neutral
    always_comb begin
        occ_d = occ_q + (accept ? OW'(1) : OW'(0)) - (release_frame ? OW'(F) : OW'(0));
    end

    // Frame storage write port
    always_comb begin
        mem_d = mem_q;
        if (capture) begin
            mem_d[wr_q][cap_idx] = dp_out;
        end
    end

    // Output view: read bank when a frame is presented, zeros otherwise
    always_comb begin
        frame_data = '0;
        if (frame_valid) begin
            for (int k = 0; k < F; k++) begin
                frame_data[W*k +: W] = mem_q[rd_q][k];
            end
        end
    end

    // Control state registers with synchronous clear
    always_ff @(posedge clk) begin
        if (clr) begin
            tag_v_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tag_idx_q[i] <= '0;
            end
            fill_q[0] <= '0;
            fill_q[1] <= '0;
            full_q    <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            occ_q     <= '0;
        end else begin
            tag_v_q   <= tag_v_d;
            tag_idx_q <= tag_idx_d;
            fill_q    <= fill_d;
            full_q    <= full_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            occ_q     <= occ_d;
        end
    end

    // Data storage; contents are only visible through a full flag, so no clear needed
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef DCT_COLLECT_ERRCHK_EN
    logic [F-1:0] mask_q [2];
    logic [F-1:0] mask_d [2];
    logic         err_q, err_d;

    // Written masks flag duplicate slot writes; issuing into a stall is also an error
    always_comb begin
        mask_d = mask_q;
        err_d  = err_q;
        if (capture) begin
            if (mask_q[wr_q][cap_idx]) begin
                err_d = 1'b1;
            end
            if (bank_done) begin
                mask_d[wr_q] = '0;
            end else begin
                mask_d[wr_q][cap_idx] = 1'b1;
            end
        end
        if (issue_valid && !issue_ready) begin
            err_d = 1'b1;
        end
    end

    // Checker state, sticky until clr
    always_ff @(posedge clk) begin
        if (clr) begin
            mask_q[0] <= '0;
            mask_q[1] <= '0;
            err_q     <= 1'b0;
        end else begin
            mask_q <= mask_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_dct_odd_collector.sv
// tb_dct_odd_collector: scoreboard bench for dct_odd_collector.
// A delay-line model of the datapath drives dp_out; expected frames are queued as issued.
module tb_dct_odd_collector;

    localparam int LAT = 12;
    localparam int W   = 32;
    localparam int F   = 8;
    localparam int FW  = W * F;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          issue_valid = 1'b0;
    logic [2:0]    issue_idx = '0;
    logic          issue_ready;
    logic [W-1:0]  dp_out;
    logic          frame_valid;
    logic          frame_ready = 1'b0;
    logic [FW-1:0] frame_data;
`ifdef DCT_COLLECT_ERRCHK_EN
    logic          err;
`endif

    logic [W-1:0]  issue_val = '0;
    logic [W-1:0]  dp_pipe [LAT];
    logic [W-1:0]  exp_slots [F];
    int            exp_cnt = 0;
    logic [FW-1:0] exp_q [$];
    logic [FW-1:0] exp_f;
    bit            sb_en = 1'b1;
    int            n_checks = 0;
    int            n_fails = 0;

    dct_odd_collector dut (
        .clk         (clk),
        .clr         (clr),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issue_ready (issue_ready),
        .dp_out      (dp_out),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data)
`ifdef DCT_COLLECT_ERRCHK_EN
        ,
        .err         (err)
`endif
    );

    always #5 clk = ~clk;

    // Datapath model: result appears LAT cycles after the issue cycle
    always @(posedge clk) begin
        dp_pipe[0] <= issue_valid ? issue_val : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) begin
            dp_pipe[i] <= dp_pipe[i-1];
        end
    end
    assign dp_out = dp_pipe[LAT-1];

    task automatic check_eq(input string tag, input logic [FW-1:0] got,
                            input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack_exp();
        logic [FW-1:0] f;
        for (int k = 0; k < F; k++) begin
            f[W*k +: W] = exp_slots[k];
        end
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one word, waiting (bounded) for issue_ready
    task automatic do_issue(input logic [2:0] idx, input logic [W-1:0] val);
        int n;
        n = 0;
        while (!issue_ready && n < 64) begin
            step();
            n++;
        end
        if (n >= 64) begin
            check_eq("issue_ready_timeout", issue_ready, 1);
        end
        issue_valid = 1'b1;
        issue_idx   = idx;
        issue_val   = val;
        exp_slots[idx] = val;
        exp_cnt++;
        if (exp_cnt == F) begin
            exp_q.push_back(pack_exp());
            exp_cnt = 0;
        end
        step();
        issue_valid = 1'b0;
    endtask

    task automatic do_reset();
        clr         = 1'b1;
        issue_valid = 1'b0;
        frame_ready = 1'b0;
        step();
        step();
        clr     = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic release_one();
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
    endtask

    // cnt holds cycles elapsed since the first issue of the frame
    task automatic wait_valid(inout int cnt);
        while (!frame_valid && cnt < 200) begin
            step();
            cnt++;
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_frame_valid", frame_valid, 0);
        check_eq("rst_frame_data", frame_data, 0);
        check_eq("rst_issue_ready", issue_ready, 1);
`ifdef DCT_COLLECT_ERRCHK_EN
        check_eq("rst_err", err, 0);
`endif
    endtask

    // Scoreboard: compare every handshaken frame against the oldest expected frame
    always @(negedge clk) begin
        if (sb_en && !clr && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("frame_unexpected", frame_valid, 0);
            end else begin
                exp_f = exp_q.pop_front();
                check_eq("frame_data", frame_data, exp_f);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [W-1:0] v;

        // Reset state
        do_reset();
        check_reset_state();

        // Basic frame, fixed pattern, latency to frame_valid
        for (int k = 0; k < F; k++) begin
            do_issue(3'(k), 32'h3F80_0000 + 32'(k));
        end
        cnt = F;
        wait_valid(cnt);
        check_eq("first_valid_latency", cnt, LAT + F);
        check_eq("slot0", frame_data[0 +: W], 32'h3F80_0000);
        check_eq("slot7", frame_data[7*W +: W], 32'h3F80_0007);
        release_one();
        check_eq("valid_after_release", frame_valid, 0);

        // Back-pressure: 16 issues fill both banks, then one release frees 8
        for (int k = 0; k < 2 * F; k++) begin
            check_eq("ready_before_issue", issue_ready, 1);
            do_issue(3'(k % F), $urandom);
        end
        check_eq("ready_low_occ16", issue_ready, 0);
        for (int i = 0; i < LAT + 2; i++) step();
        check_eq("ready_still_low", issue_ready, 0);
        check_eq("valid_bp", frame_valid, 1);
        release_one();
        check_eq("ready_after_pulse", issue_ready, 1);
        check_eq("valid_second_frame", frame_valid, 1);
        check_eq("second_frame_visible", frame_data, exp_q[0]);
        release_one();
        check_eq("valid_drained", frame_valid, 0);

        // Release frame 1 in the same cycle frame 2 slot 7 is captured
        for (int k = 0; k < 2 * F; k++) begin
            do_issue(3'(k % F), $urandom);
        end
        for (int i = 0; i < LAT - 1; i++) step();
        check_eq("valid_before_overlap", frame_valid, 1);
        release_one();
        check_eq("valid_after_overlap", frame_valid, 1);
        check_eq("overlap_frame2", frame_data, exp_q[0]);
        release_one();
        check_eq("valid_overlap_done", frame_valid, 0);

        // clr with 5 tags in flight
        for (int k = 0; k < 5; k++) begin
            do_issue(3'(k), $urandom);
        end
        do_reset();
        check_reset_state();
        for (int i = 0; i < LAT; i++) begin
            check_eq("no_stale_capture", frame_valid, 0);
            step();
        end
        for (int k = 0; k < F; k++) begin
            do_issue(3'(k), 32'h4000_0000 + 32'(k * 3));
        end
        cnt = F;
        wait_valid(cnt);
        check_eq("post_clr_latency", cnt, LAT + F);
        release_one();

        // Reverse index order
        for (int k = F - 1; k >= 0; k--) begin
            do_issue(3'(k), 32'hC000_0000 + 32'(k << 4));
        end
        cnt = F;
        wait_valid(cnt);
        check_eq("rev_slot2", frame_data[2*W +: W], 32'hC000_0020);
        release_one();

        // Streaming with frame_ready held; issue_ready throttles as occupancy demands
        frame_ready = 1'b1;
        for (int k = 0; k < 4 * F; k++) begin
            do_issue(3'(k % F), $urandom);
        end
        for (int i = 0; i < LAT + F + 4; i++) step();
        frame_ready = 1'b0;
        check_eq("stream_drained", exp_q.size(), 0);
        check_eq("stream_ready", issue_ready, 1);

        // Duplicate idx 3 within a frame (slot 4 holds stale data, so no full compare)
        sb_en = 1'b0;
        v = 32'h1234_5678;
        do_issue(3'd0, $urandom);
        do_issue(3'd1, $urandom);
        do_issue(3'd2, $urandom);
        do_issue(3'd3, $urandom);
        do_issue(3'd3, v);
        do_issue(3'd5, $urandom);
        do_issue(3'd6, $urandom);
        do_issue(3'd7, $urandom);
        cnt = F;
        while (!frame_valid && cnt < 200) begin
`ifdef DCT_COLLECT_ERRCHK_EN
            if (cnt == LAT + 4) check_eq("err_before_dup", err, 0);
            if (cnt == LAT + 5) check_eq("err_on_dup", err, 1);
`endif
            step();
            cnt++;
        end
        check_eq("dup_latency", cnt, LAT + F);
        check_eq("dup_slot3", frame_data[3*W +: W], v);
        release_one();
        check_eq("dup_released", frame_valid, 0);
`ifdef DCT_COLLECT_ERRCHK_EN
        check_eq("err_sticky", err, 1);
`endif
        do_reset();
        check_reset_state();
        exp_q.delete();
        sb_en = 1'b1;

        check_eq("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
